mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide engine that owns the HI/LO register pair.
- The ALU hands off mult/div operands and takes the results back through mfhi/mflo, so this block is the producer end of the HI/LO interface the single-cycle ALU consumes.
- Uses radix-2 iterative shift-add / restoring division.
- Start/busy/done handshake lets the control path stall while the operation runs.

---
 rtl/mult_div_unit.sv | 138 +++++++++++++
 tb/tb_mult_div_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle radix-2 multiply/divide engine owning HI/LO
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic             is_div, neg_q, neg_r;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo;

  logic             a_neg, b_neg, launch_dz;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  // Signedness only matters for op[0]; unsigned ops see non-negative operands.
  assign a_neg     = op[0] & operand_a[WIDTH-1];
  assign b_neg     = op[0] & operand_b[WIDTH-1];
  assign abs_a     = a_neg ? -operand_a : operand_a;
  assign abs_b     = b_neg ? -operand_b : operand_b;
  assign launch_dz = op[1] && (operand_b == '0);

  assign busy = (state != IDLE);

  // Shift-add multiply: acc_lo holds the multiplier and absorbs product bits.
  assign mul_addend = acc_lo[0] ? opnd : '0;
  assign mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};

  // Restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      fix_hi = neg_r ? -acc_hi : acc_hi;
      fix_lo = neg_q ? -acc_lo : acc_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = launch_dz ? FIX : CALC;
      CALC:    if (count == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      opnd        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op[1];
            div_by_zero <= launch_dz;
            count       <= CW'(WIDTH - 1);
            if (launch_dz) begin
              acc_hi <= operand_a;
              acc_lo <= '1;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
            end else begin
              acc_hi <= '0;
              opnd   <= op[1] ? abs_b : abs_a;
              acc_lo <= op[1] ? abs_a : abs_b;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
            end
          end else begin
            if (write_hi) hi <= write_data;
            if (write_lo) lo <= write_data;
          end
        end
        CALC: begin
          count <= count - 1'b1;
          if (is_div) {acc_hi, acc_lo} <= {div_rem, acc_lo[WIDTH-2:0], div_ge};
          else        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        write_hi, write_lo;
  logic [31:0] write_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural rules.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = int'(a);
    sb = int'(b);
    ez = 1'b0;
    case (o)
      2'b00: begin up = {32'b0, a} * {32'b0, b}; {eh, el} = up; end
      2'b01: begin sp = longint'(sa) * longint'(sb); {eh, el} = sp; end
      2'b10: begin
        if (b == 0) begin eh = a; el = 32'hFFFFFFFF; ez = 1'b1; end
        else begin el = a / b; eh = a % b; end
      end
      default: begin
        if (b == 0) begin eh = a; el = 32'hFFFFFFFF; ez = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin el = 32'h80000000; eh = 0; end
        else begin el = sa / sb; eh = sa % sb; end
      end
    endcase
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic        ez;
    int          lat, bcnt, exp_lat;
    model(o, a, b, eh, el, ez);
    exp_lat = (o[1] && b == 0) ? 1 : 33;
    launch(o, a, b);
    wait_done(lat, bcnt);
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".lo"}, 64'(lo), 64'(el));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(ez));
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, bcnt;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    chk("reset.dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // multu 5*6 with a stray start and mthi arriving mid-operation
    launch(2'b00, 32'd5, 32'd6);
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == 9) begin
        @(negedge clk);
        start = 1'b1; op = 2'b11; operand_a = $urandom; operand_b = $urandom;
        write_hi = 1'b1; write_data = 32'hDEADBEEF;
      end else if (lat == 10) begin
        @(negedge clk);
        start = 1'b0; write_hi = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore.latency", 64'(lat), 64'd33);
    chk("ignore.busy_cycles", 64'(bcnt), 64'd33);
    chk("ignore.hi", 64'(hi), 64'd0);
    chk("ignore.lo", 64'(lo), 64'd30);

    @(negedge clk);
    write_lo = 1'b1; write_data = 32'h1234;
    @(posedge clk); #1;
    write_lo = 1'b0;
    chk("mtlo.lo", 64'(lo), 64'h1234);
    chk("mtlo.hi", 64'(hi), 64'd0);
    chk("mtlo.done", 64'(done), 64'd0);
    chk("mtlo.busy", 64'(busy), 64'd0);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max.hi_const", 64'(hi), 64'hFFFFFFFE);
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7);
    chk("mult_neg.lo_const", 64'(lo), 64'hFFFFFFEB);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2);
    chk("div_neg.lo_const", 64'(lo), 64'hFFFFFFFD);

    // asynchronous reset abandons a divide in flight
    launch(2'b10, 32'd1000, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.hi", 64'(hi), 64'd0);
    chk("abort.lo", 64'(lo), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("divu_9_4", 2'b10, 32'd9, 32'd4);
    chk("divu_9_4.lo_const", 64'(lo), 64'd2);

    run_op("div_intmin", 2'b11, 32'h80000000, 32'hFFFFFFFF);
    chk("div_intmin.lo_const", 64'(lo), 64'h80000000);
    run_op("divu_zero", 2'b10, 32'd100, 32'd0);
    chk("divu_zero.dbz_const", 64'(div_by_zero), 64'd1);
    run_op("after_dz", 2'b00, 32'd2, 32'd3);
    chk("after_dz.lo_const", 64'(lo), 64'd6);
    run_op("div_zero", 2'b11, 32'h80000001, 32'd0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
